// File: rtl/tiny_dnn_layer_seq_if.sv
// Accelerator-side bundle for the tiny_dnn layer sequencer.
// Carries the source/result stream handshakes the sequencer observes
// and the mode/flag/layer outputs it drives into the accelerator top.
//   master : the sequencer (observes handshakes, drives mode outputs)
//   slave  : the accelerator top (drives handshakes, consumes mode outputs)
//   src_valid, src_ready           : source-stream handshake
//   dst_valid, dst_ready, dst_last : result-stream handshake
//   wwrite, bwrite, run            : mode outputs, at most one high
//   backprop, enbias               : current layer flags
//   layer                          : current layer index
interface tiny_dnn_layer_seq_if #(
    parameter int unsigned LW = 2
);
    logic          src_valid;
    logic          src_ready;
    logic          dst_valid;
    logic          dst_ready;
    logic          dst_last;
    logic          wwrite;
    logic          bwrite;
    logic          run;
    logic          backprop;
    logic          enbias;
    logic [LW-1:0] layer;

    modport master (
        input  src_valid, src_ready, dst_valid, dst_ready, dst_last,
        output wwrite, bwrite, run, backprop, enbias, layer
    );

    modport slave (
        output src_valid, src_ready, dst_valid, dst_ready, dst_last,
        input  wwrite, bwrite, run, backprop, enbias, layer
    );
endinterface

// File: rtl/tiny_dnn_layer_seq.sv
// Layer sequencer for the tiny_dnn accelerator.
// Holds an L_NUM-entry descriptor table {wcnt, bcnt, nbatch, backprop, enbias}
// and on start walks layers 0..nlayers-1, running weight load, bias load and
// the compute batch for each, with a one-cycle all-low GAP before every phase.
// Optional cycle counter enabled by defining TINY_DNN_LAYER_SEQ_PERF_EN.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cfg_*          : descriptor write port, accepted only while idle
//   nlayers        : number of layers to run, sampled on an accepted start
//   start, abort   : sequence control
//   acc            : accelerator bundle (handshakes in, mode/flags/layer out)
//   busy           : high in every non-idle state
//   done           : one-cycle pulse at sequence end (normal or aborted)
//   perf_cycles    : busy-cycle count (0 when the counter is not built)
module tiny_dnn_layer_seq #(
    parameter int unsigned L_NUM = 4,
    parameter int unsigned LW    = $clog2(L_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [LW-1:0]               cfg_addr,
    input  logic [11:0]                 cfg_wcnt,
    input  logic [7:0]                  cfg_bcnt,
    input  logic [7:0]                  cfg_nbatch,
    input  logic                        cfg_backprop,
    input  logic                        cfg_enbias,
    input  logic [LW:0]                 nlayers,
    input  logic                        start,
    input  logic                        abort,
    tiny_dnn_layer_seq_if.master        acc,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 perf_cycles
);

    typedef struct packed {
        logic [11:0] wcnt;
        logic [7:0]  bcnt;
        logic [7:0]  nbatch;
        logic        backprop;
        logic        enbias;
    } desc_t;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StWload,
        StBload,
        StRun,
        StNext,
        StFin
    } state_e;

    // Next phase the GAP state should consider for the current layer.
    typedef enum logic [1:0] {
        PhW,
        PhB,
        PhR
    } phase_e;

    desc_t         desc_mem [L_NUM];
    desc_t         cur_desc;
    desc_t         nxt_desc;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [LW:0]   nlay_q, nlay_d;
    logic [11:0]   beat_cnt_q, beat_cnt_d;
    logic [7:0]    smp_cnt_q, smp_cnt_d;

    logic          wwrite_q, bwrite_q, run_q;
    logic          backprop_q, enbias_q;
    logic          busy_q, done_q;
    logic          flags_d_valid;

    logic          beat;
    logic          smp_end;

    assign beat    = acc.src_valid & acc.src_ready;
    assign smp_end = acc.dst_valid & acc.dst_ready & acc.dst_last;

    // Descriptor table: no reset, contents only change while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle)) begin
            desc_mem[cfg_addr] <= '{
                wcnt:     cfg_wcnt,
                bcnt:     cfg_bcnt,
                nbatch:   cfg_nbatch,
                backprop: cfg_backprop,
                enbias:   cfg_enbias
            };
        end
    end

    assign cur_desc = desc_mem[layer_q];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        layer_d    = layer_q;
        nlay_d     = nlay_q;
        beat_cnt_d = beat_cnt_q;
        smp_cnt_d  = smp_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (nlayers == '0) begin
                        state_d = StFin;
                    end else begin
                        nlay_d  = nlayers;
                        layer_d = '0;
                        phase_d = PhW;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                // Counters are cleared here so every phase starts from zero.
                beat_cnt_d = '0;
                smp_cnt_d  = '0;
                if ((phase_q == PhW) && (cur_desc.wcnt != '0)) begin
                    state_d = StWload;
                end else if ((phase_q != PhR) && (cur_desc.bcnt != '0)) begin
                    state_d = StBload;
                end else if (cur_desc.nbatch != '0) begin
                    state_d = StRun;
                end else begin
                    state_d = StNext;
                end
            end
            StWload: begin
                if (beat) begin
                    if (beat_cnt_q == (cur_desc.wcnt - 12'd1)) begin
                        phase_d = PhB;
                        state_d = StGap;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 12'd1;
                    end
                end
            end
            StBload: begin
                if (beat) begin
                    if (beat_cnt_q == ({4'd0, cur_desc.bcnt} - 12'd1)) begin
                        phase_d = PhR;
                        state_d = StGap;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 12'd1;
                    end
                end
            end
            StRun: begin
                if (smp_end) begin
                    if (smp_cnt_q == (cur_desc.nbatch - 8'd1)) begin
                        state_d = StNext;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                    end
                end
            end
            StNext: begin
                // The last layer index is kept on the way to FIN so layer never
                // wraps past the table when nlayers == L_NUM.
                if (({1'b0, layer_q} + (LW+1)'(1)) == nlay_q) begin
                    state_d = StFin;
                end else begin
                    layer_d = layer_q + LW'(1);
                    phase_d = PhW;
                    state_d = StGap;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any terminal beat taken above.
        if (abort && (state_q != StIdle) && (state_q != StFin)) begin
            state_d = StFin;
        end
    end

    // Flags follow the descriptor of the layer being entered, 0 outside a layer.
    assign nxt_desc      = desc_mem[layer_d];
    assign flags_d_valid = (state_d == StGap) || (state_d == StWload) ||
                           (state_d == StBload) || (state_d == StRun) ||
                           (state_d == StNext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= PhW;
            layer_q    <= '0;
            nlay_q     <= '0;
            beat_cnt_q <= '0;
            smp_cnt_q  <= '0;
            wwrite_q   <= 1'b0;
            bwrite_q   <= 1'b0;
            run_q      <= 1'b0;
            backprop_q <= 1'b0;
            enbias_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            layer_q    <= layer_d;
            nlay_q     <= nlay_d;
            beat_cnt_q <= beat_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            wwrite_q   <= (state_d == StWload);
            bwrite_q   <= (state_d == StBload);
            run_q      <= (state_d == StRun);
            backprop_q <= flags_d_valid & nxt_desc.backprop;
            enbias_q   <= flags_d_valid & nxt_desc.enbias;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StFin);
        end
    end

    assign acc.wwrite   = wwrite_q;
    assign acc.bwrite   = bwrite_q;
    assign acc.run      = run_q;
    assign acc.backprop = backprop_q;
    assign acc.enbias   = enbias_q;
    assign acc.layer    = layer_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef TINY_DNN_LAYER_SEQ_PERF_EN
    logic        start_acc;
    logic [31:0] perf_q;

    assign start_acc = (state_q == StIdle) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
